// File: rtl/xbar_port_alloc.sv
// Deflection port allocator for a 4x4 router crossbar: ranks flits, grants output ports, registers selects.
// Optional deflection statistics counter built only when XBAR_DEFLECT_STAT_EN is defined.
module xbar_port_alloc #(
    parameter int unsigned AGE_W        = 8,
    parameter int unsigned ID_W         = 4,
    parameter int unsigned GOLDEN_EPOCH = 64,
    parameter int unsigned STAT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           in_valid,
    input  logic [15:0]          in_ppv,
    input  logic [4*AGE_W-1:0]   in_age,
    input  logic [4*ID_W-1:0]    in_src,
    output logic [3:0]           rank_valid,
    output logic [15:0]          rank_pv,
    output logic [7:0]           rank_idx,
    output logic [3:0]           rank_defl,
    output logic [ID_W-1:0]      golden_id,
    output logic [STAT_W-1:0]    deflect_cnt
);

    localparam int unsigned EP_W  = $clog2(GOLDEN_EPOCH);
    localparam int unsigned KEY_W = 2 + AGE_W + 2;

    logic [EP_W-1:0]  ep_q, ep_d;
    logic [ID_W-1:0]  golden_q, golden_d;
    logic [3:0]       rank_valid_q, rank_valid_d;
    logic [15:0]      rank_pv_q, rank_pv_d;
    logic [7:0]       rank_idx_q, rank_idx_d;
    logic [3:0]       rank_defl_q, rank_defl_d;

    logic [KEY_W-1:0] key [4];
    logic [1:0]       beat;
    logic [1:0]       sel;
    logic [3:0]       free;
    logic [3:0]       cand;
    logic [3:0]       grant;

    // Golden epoch: counter wraps at GOLDEN_EPOCH-1 and advances the golden source id
    always_comb begin
        ep_d     = ep_q + EP_W'(1);
        golden_d = golden_q;
        if (ep_q == EP_W'(GOLDEN_EPOCH - 1)) begin
            ep_d     = '0;
            golden_d = golden_q + ID_W'(1);
        end
    end

    // Rank by key {valid, golden, age, inverted index}; then allocate ports in rank order
    always_comb begin
        rank_valid_d = '0;
        rank_pv_d    = '0;
        rank_idx_d   = '0;
        rank_defl_d  = '0;
        beat         = '0;
        sel          = '0;
        free         = 4'b1111;
        cand         = '0;
        grant        = '0;

        for (int i = 0; i < 4; i++) begin
            if (in_valid[i]) begin
                key[i] = {1'b1, (in_src[i*ID_W +: ID_W] == golden_q),
                          in_age[i*AGE_W +: AGE_W], ~2'(i)};
            end else begin
                key[i] = {2'b00, {AGE_W{1'b0}}, ~2'(i)};
            end
        end

        // Rank position of input i is the number of inputs whose key beats it
        for (int i = 0; i < 4; i++) begin
            beat = '0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && key[j] > key[i]) begin
                    beat = beat + 2'd1;
                end
            end
            rank_idx_d[2*beat +: 2] = 2'(i);
        end

        for (int k = 0; k < 4; k++) begin
            sel             = rank_idx_d[2*k +: 2];
            rank_valid_d[k] = in_valid[sel];
            if (in_valid[sel]) begin
                cand = in_ppv[4*sel +: 4] & free;
                if (cand == 4'b0000) begin
                    cand           = free;
                    rank_defl_d[k] = 1'b1;
                end
                grant                = cand & (~cand + 4'd1);
                rank_pv_d[4*k +: 4]  = grant;
                free                 = free & ~grant;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ep_q         <= '0;
            golden_q     <= '0;
            rank_valid_q <= '0;
            rank_pv_q    <= '0;
            rank_idx_q   <= '0;
            rank_defl_q  <= '0;
        end else begin
            ep_q         <= ep_d;
            golden_q     <= golden_d;
            rank_valid_q <= rank_valid_d;
            rank_pv_q    <= rank_pv_d;
            rank_idx_q   <= rank_idx_d;
            rank_defl_q  <= rank_defl_d;
        end
    end

`ifdef XBAR_DEFLECT_STAT_EN
    localparam int unsigned SUM_W = STAT_W + 3;

    logic [STAT_W-1:0] stat_q, stat_d;
    logic [SUM_W-1:0]  stat_sum;

    // Saturating accumulation of this cycle's deflections
    always_comb begin
        stat_sum = SUM_W'(stat_q) + SUM_W'($countones(rank_defl_d));
        stat_d   = stat_sum[STAT_W-1:0];
        if (stat_sum > SUM_W'({STAT_W{1'b1}})) begin
            stat_d = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign deflect_cnt = stat_q;
`else
    assign deflect_cnt = '0;
`endif

    assign rank_valid = rank_valid_q;
    assign rank_pv    = rank_pv_q;
    assign rank_idx   = rank_idx_q;
    assign rank_defl  = rank_defl_q;
    assign golden_id  = golden_q;

endmodule

// File: tb/tb_xbar_port_alloc.sv
// Scoreboard bench for xbar_port_alloc: driver pushes reference-model expectations, monitor pops and compares.
module tb_xbar_port_alloc;

    localparam int unsigned AGE_W  = 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned EPOCH  = 64;
    localparam int unsigned STAT_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        in_valid = '0;
    logic [15:0]       in_ppv = '0;
    logic [4*AGE_W-1:0] in_age = '0;
    logic [4*ID_W-1:0] in_src = '0;
    logic [3:0]        rank_valid;
    logic [15:0]       rank_pv;
    logic [7:0]        rank_idx;
    logic [3:0]        rank_defl;
    logic [ID_W-1:0]   golden_id;
    logic [STAT_W-1:0] deflect_cnt;

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] pv;
        logic [7:0]  idx;
        logic [3:0]  defl;
        logic [3:0]  gid;
        logic [15:0] dc;
    } exp_t;

    exp_t   exp_q[$];
    int     tests = 0;
    int     errors = 0;
    int     n_edges = 0;
    longint dcnt = 0;

    xbar_port_alloc #(
        .AGE_W(AGE_W), .ID_W(ID_W), .GOLDEN_EPOCH(EPOCH), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ppv(in_ppv),
        .in_age(in_age), .in_src(in_src), .rank_valid(rank_valid), .rank_pv(rank_pv),
        .rank_idx(rank_idx), .rank_defl(rank_defl), .golden_id(golden_id),
        .deflect_cnt(deflect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: score-sort the inputs, then first-fit port search per rank
    function automatic exp_t model(logic [3:0] v, logic [15:0] ppv, logic [31:0] age,
                                   logic [15:0] src, logic [3:0] g);
        exp_t     e;
        int       score[4];
        bit       used[4];
        bit [3:0] fr;
        int       best;
        int       port;
        e  = '{default: '0};
        fr = 4'hF;
        for (int i = 0; i < 4; i++) begin
            score[i] = v[i] ? 100000 + ((src[4*i +: 4] == g) ? 1000 : 0) + int'(age[8*i +: 8]) : 0;
            used[i]  = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            best = -1;
            for (int i = 0; i < 4; i++) begin
                if (!used[i]) begin
                    if (best < 0) best = i;
                    else if (score[i] > score[best]) best = i;
                end
            end
            used[best] = 1'b1;
            e.idx[2*k +: 2] = 2'(best);
            if (v[best]) begin
                e.rv[k] = 1'b1;
                port = -1;
                for (int p = 0; p < 4; p++)
                    if (port < 0 && ppv[4*best + p] && fr[p]) port = p;
                if (port < 0) begin
                    e.defl[k] = 1'b1;
                    for (int p = 0; p < 4; p++)
                        if (port < 0 && fr[p]) port = p;
                end
                e.pv[4*k + port] = 1'b1;
                fr[port] = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic drive(bit rst, logic [3:0] v, logic [15:0] ppv, logic [31:0] age,
                         logic [15:0] src, bit dir, exp_t de);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        in_ppv   = ppv;
        in_age   = age;
        in_src   = src;
        if (rst) begin
            n_edges = 0;
            dcnt    = 0;
            e = '{default: '0};
        end else begin
            e = dir ? de : model(v, ppv, age, src, 4'((n_edges / EPOCH) % 16));
            n_edges++;
            e.gid = 4'((n_edges / EPOCH) % 16);
`ifdef XBAR_DEFLECT_STAT_EN
            dcnt += $countones(e.defl);
            if (dcnt > 65535) dcnt = 65535;
`endif
            e.dc = 16'(dcnt);
        end
        exp_q.push_back(e);
    endtask

    task automatic rnd(bit rst);
        logic [3:0]  v;
        logic [15:0] ppv;
        logic [31:0] age;
        logic [15:0] src;
        logic [3:0]  g;
        exp_t        none;
        none = '{default: '0};
        g    = 4'((n_edges / EPOCH) % 16);
        v    = 4'($urandom);
        ppv  = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            age[8*i +: 8] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            src[4*i +: 4] = ($urandom_range(0, 3) == 0) ? g : 4'($urandom);
        end
        drive(rst, v, ppv, age, src, 1'b0, none);
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rank_valid", 32'(rank_valid), 32'(e.rv));
                chk("rank_pv", 32'(rank_pv), 32'(e.pv));
                chk("rank_idx", 32'(rank_idx), 32'(e.idx));
                chk("rank_defl", 32'(rank_defl), 32'(e.defl));
                chk("golden_id", 32'(golden_id), 32'(e.gid));
                chk("deflect_cnt", 32'(deflect_cnt), 32'(e.dc));
            end
        end
    end

    initial begin
        exp_t        d;
        exp_t        none;
        logic [3:0]  g;
        logic [31:0] age;
        logic [15:0] src;
        none = '{default: '0};

        repeat (4) rnd(1'b1);
        drive(1'b0, 4'b0000, 16'h0000, 32'h0, 16'h0, 1'b0, none);

        // All want port0; ages {10,40,20,30}, no golden flit
        g   = 4'((n_edges / EPOCH) % 16);
        src = {4{g + 4'd1}};
        d   = '{rv: 4'hF, pv: 16'h8421, idx: 8'h2D, defl: 4'b1110, gid: 4'h0, dc: 16'h0};
        drive(1'b0, 4'hF, 16'h1111, {8'd30, 8'd20, 8'd40, 8'd10}, src, 1'b1, d);

        // Equal ages, disjoint productive ports
        d   = '{rv: 4'hF, pv: 16'h8421, idx: 8'hE4, defl: 4'b0000, gid: 4'h0, dc: 16'h0};
        drive(1'b0, 4'hF, 16'h8421, {4{8'd5}}, src, 1'b1, d);

        // Golden input2 with age 0 outranks age-200 flits; all want port2
        g   = 4'((n_edges / EPOCH) % 16);
        src = {g + 4'd1, g, g + 4'd1, g + 4'd1};
        age = {8'd200, 8'd0, 8'd200, 8'd200};
        d   = '{rv: 4'hF, pv: 16'h8214, idx: 8'hD2, defl: 4'b1110, gid: 4'h0, dc: 16'h0};
        drive(1'b0, 4'hF, 16'h4444, age, src, 1'b1, d);

        repeat (300) rnd(1'b0);

        // Async reset mid-run clears outputs without waiting for an edge
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rank_valid", 32'(rank_valid), 32'h0);
        chk("async_rank_pv", 32'(rank_pv), 32'h0);
        chk("async_rank_idx", 32'(rank_idx), 32'h0);
        chk("async_golden_id", 32'(golden_id), 32'h0);
        chk("async_deflect_cnt", 32'(deflect_cnt), 32'h0);
        repeat (2) rnd(1'b1);

        repeat (1100) rnd(1'b0);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
